// File: rtl/uart_tx_engine_if.sv
// Upstream byte handshake for uart_tx_engine: the host drives tx_data/tx_valid
// and the transmitter answers with tx_ready.
interface uart_tx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: one frame per accepted byte, bits advanced on baud_tick.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             baud_tick,
  uart_tx_engine_if.slave  up,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             tx_done
);
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
  logic                 ready;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign ready       = (state_q == IDLE) && !reset;
  assign up.tx_ready = ready;
  assign tx_busy     = (state_q != IDLE);
  assign tx_out      = out_q;
  assign tx_done     = done_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    out_d      = out_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      // A tick coinciding with the accept is deliberately ignored here:
      // SYNC makes the start bit wait for the next full bit period.
      IDLE: if (up.tx_valid && ready) begin
        shift_d = up.tx_data;
`ifdef UART_TX_PARITY_EN
        par_d   = (^up.tx_data) ^ (PARITY_ODD != 0);
`endif
        state_d = SYNC;
      end
      SYNC: if (baud_tick) begin
        out_d   = 1'b0;
        state_d = START;
      end
      START: if (baud_tick) begin
        out_d     = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: if (baud_tick) begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          out_d   = par_q;
          state_d = PARITY;
`else
          out_d   = 1'b1;
          state_d = STOP;
`endif
        end else begin
          out_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_tick) begin
        out_d   = 1'b1;
        state_d = STOP;
      end
`endif
      STOP: if (baud_tick) begin
        if (stop_cnt_q == LAST_STOP) begin
          stop_cnt_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      out_q      <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      out_q      <= out_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a
// line monitor rebuilds frames at tick boundaries and compares.
module tb_uart_tx_engine;
  localparam int DB   = 8;
  localparam int SB   = 2;
  localparam int PODD = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLEN = 1 + DB + PB + SB;

  logic in_clk = 1'b0;
  logic reset = 1'b1;
  logic baud_tick = 1'b0;
  logic tx_out, tx_busy, tx_done;

  uart_tx_engine_if #(.DATA_BITS(DB)) up();

  uart_tx_engine #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
    .in_clk(in_clk), .reset(reset), .baud_tick(baud_tick), .up(up),
    .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 in_clk = ~in_clk;

  int tick_div = 16;
  int tick_cnt = 0;
  always @(posedge in_clk) begin
    #2;
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      baud_tick = 1'b1;
    end else begin
      tick_cnt++;
      baud_tick = 1'b0;
    end
  end

  bit scramble = 1'b0;
  always @(posedge in_clk) begin
    #4;
    if (scramble) up.tx_data = 8'($urandom);
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line image of one frame, bit 0 first; unused upper bits are idle-high.
  function automatic logic [15:0] mk_frame(input logic [7:0] b);
    logic [15:0] f;
    int i;
    f = '1;
    f[0] = 1'b0;
    for (int k = 0; k < DB; k++) f[1 + k] = b[k];
    i = 1 + DB;
`ifdef UART_TX_PARITY_EN
    f[i] = (^b[DB-1:0]) ^ (PODD != 0);
    i++;
`endif
    for (int s = 0; s < SB; s++) f[i + s] = 1'b1;
    return f;
  endfunction

  // Monitor: samples the line on the cycle after each tick edge.
  logic tick_edge = 1'b0;
  logic rst_edge = 1'b1;
  always @(posedge in_clk) begin
    tick_edge <= baud_tick;
    rst_edge  <= reset;
  end

  logic        prev_out = 1'b1;
  bit          in_frame = 1'b0;
  int          idx = 0;
  logic [15:0] got = '1;
  always @(negedge in_clk) begin
    bit exp_done;
    exp_done = 1'b0;
    if (rst_edge) begin
      if (in_frame) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        in_frame = 1'b0;
      end
    end else begin
      if (tx_out !== prev_out && !tick_edge) chk("glitch", 32'(tx_out), 32'(prev_out));
      if (tick_edge) begin
        if (in_frame) begin
          if (idx == FLEN) begin
            exp_done = 1'b1;
            chk("done_pulse", 32'(tx_done), 1);
            chk("busy_after_frame", 32'(tx_busy), 0);
            if (exp_q.size() == 0) chk("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
            else chk("frame", 32'(got), 32'(exp_q.pop_front()));
            in_frame = 1'b0;
          end else begin
            got[idx] = tx_out;
            idx++;
            chk("busy_in_frame", 32'(tx_busy), 1);
          end
        end else if (tx_out === 1'b0) begin
          in_frame = 1'b1;
          got = '1;
          got[0] = 1'b0;
          idx = 1;
          chk("busy_at_start", 32'(tx_busy), 1);
        end
      end
    end
    if (tx_done === 1'b1) begin
      done_cnt++;
      if (!exp_done) chk("spurious_done", 32'(tx_done), 0);
    end
    prev_out = tx_out;
  end

  task automatic cyc();
    @(posedge in_clk);
    #3;
  endtask

  task automatic accept(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(mk_frame(b));
    up.tx_data = b;
    up.tx_valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (up.tx_ready) begin
        ok = 1'b1;
        cyc();
        break;
      end
      cyc();
    end
    up.tx_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Counts tick edges from the accept until the start bit appears.
  task automatic latency();
    int n;
    bit ok, t;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      t = baud_tick;
      cyc();
      if (t) n++;
      if (tx_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) chk("start_latency_ticks", n, 1);
    else chk("start_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (!tx_busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) chk("idle_timeout", 0, 1);
    cyc();
    cyc();
  endtask

  initial begin
    int c, d0, n;
    bit busy_drop, ok;
    up.tx_data = '0;
    up.tx_valid = 1'b0;

    repeat (3) cyc();
    chk("rst_tx_out", 32'(tx_out), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_ready_low", 32'(up.tx_ready), 0);
    reset = 1'b0;
    cyc();
    chk("ready_after_rst", 32'(up.tx_ready), 1);

    // 0x55 at 216 clocks per bit; done follows the falling edge by FLEN bits
    tick_div = 216;
    accept(8'h55);
    latency();
    c = 0;
    busy_drop = 1'b0;
    while (tx_done !== 1'b1 && c < 5000) begin
      cyc();
      c++;
      if (!tx_busy && !tx_done) busy_drop = 1'b1;
    end
    chk("done_latency_clks", c, FLEN * 216);
    chk("busy_throughout", 32'(busy_drop), 0);
    wait_idle();

    tick_div = 16;
    repeat (20) cyc();
    accept(8'hA3);
    latency();
    wait_idle();

    // accept lands on a tick edge; start must wait for the following tick
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (baud_tick && up.tx_ready) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) chk("coincident_setup", 0, 1);
    accept(8'h3C);
    latency();
    wait_idle();

    // back-to-back with tx_valid held
    d0 = done_cnt;
    exp_q.push_back(mk_frame(8'h01));
    up.tx_data = 8'h01;
    up.tx_valid = 1'b1;
    for (int i = 0; i < 100 && !up.tx_ready; i++) cyc();
    cyc();
    up.tx_data = 8'h02;
    exp_q.push_back(mk_frame(8'h02));
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (up.tx_ready) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) chk("b2b_ready_timeout", 0, 1);
    chk("b2b_ready_with_done", 32'(tx_done), 1);
    cyc();
    chk("b2b_ready_one_cycle", 32'(up.tx_ready), 0);
    up.tx_valid = 1'b0;
    latency();
    wait_idle();
    chk("b2b_done_count", done_cnt - d0, 2);

    // reset during data bit 3, then a clean frame
    d0 = done_cnt;
    accept(8'h96);
    latency();
    n = 0;
    for (int i = 0; i < 500 && n < 4; i++) begin
      if (baud_tick) n++;
      cyc();
    end
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    chk("mid_rst_tx_out", 32'(tx_out), 1);
    chk("mid_rst_busy", 32'(tx_busy), 0);
    reset = 1'b0;
    cyc();
    chk("mid_rst_ready", 32'(up.tx_ready), 1);
    repeat (40) cyc();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    accept(8'h5A);
    latency();
    wait_idle();
    chk("post_rst_done", done_cnt - d0, 1);

    // tx_data churns after accept; the frame must still carry 0xF0
    accept(8'hF0);
    scramble = 1'b1;
    latency();
    wait_idle();
    scramble = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial UART transmitter downstream of the baud-rate divider; consumes its one-cycle bit-period tick (baud_tick) and shifts out one frame per accepted byte, LSB first.
- Frame: 1 start bit (0), DATA_BITS data bits, optional parity bit, STOP_BITS stop bits (1).
- Upstream side is a valid/ready byte interface fed by the host or command logic.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
- in_clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-cycle pulse, once per bit period, from the divider.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte.
- tx_out  output  1  serial line; idle high; registered.
- tx_busy  output  1  a frame is pending or in progress.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (synchronous, active-high; clock in_clk): state=IDLE, tx_out=1, tx_busy=0, tx_done=0, bit and stop counters=0. tx_ready=0 while reset is high, 1 on the first cycle after release.
- Accept: tx_valid && tx_ready on a rising edge of in_clk. On that edge tx_data is captured into the shift register and the state goes to SYNC. tx_data is don't-care afterwards.
- tx_ready = (state==IDLE) && !reset.
- tx_busy = (state!=IDLE).
- All transitions below happen only on cycles where baud_tick=1; otherwise state and tx_out hold.
- A baud_tick in the same cycle as the accept is ignored.
- SYNC: tx_out stays 1. On tick: tx_out<=0, state START.
  - Latency: the falling edge of tx_out is registered on the first tick strictly after the accept cycle.
- START: on tick: tx_out<=shift[0], shift right, bit_cnt<=0, state DATA.
- DATA: on tick:
  - if bit_cnt==DATA_BITS-1: go to PARITY (macro defined) or STOP; tx_out<=parity bit or 1 respectively.
  - otherwise: tx_out<=next bit, bit_cnt++.
- PARITY (macro only): on tick: tx_out<=1, state STOP.
- STOP: on tick:
  - if stop_cnt==STOP_BITS-1: state IDLE, stop_cnt<=0, tx_done=1 for exactly that one cycle.
  - otherwise: stop_cnt++.
- Bit timing: every bit level persists exactly one tick interval. The start bit begins at tick N, data bit k at tick N+1+k, and so on.
- Back-to-back: with tx_valid held high, the next byte is accepted in the first IDLE cycle. Its start bit waits for the next tick, so the line is high for at least STOP_BITS full bit periods between frames.
- tx_out only ever changes on a baud_tick cycle or on reset; no glitches.
- Reset mid-frame: tx_out returns to 1 on the reset edge, the frame is aborted, and no tx_done is produced.
- Missing ticks: the block waits indefinitely; there is no timeout.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after the last data bit.
  - Parity bit = XOR of the captured data bits, XOR PARITY_ODD.
  - Parity is computed from the captured byte at accept time, not from the shifting register.
- Undefined:
  - No PARITY state or logic.
  - DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Test Plan:
- Divider ticks every 216 clocks, macro off, send 0x55: tx_out per bit period = 0,1,0,1,0,1,0,1,0,1; tx_done pulses once, 10 tick periods (2160 clocks) after the first falling edge; tx_busy is high throughout.
- Macro on, PARITY_ODD=0, send 0xA3: line = 0,1,1,0,0,0,1,0,1, parity 0, stop 1. With PARITY_ODD=1 the parity bit is 1; frame is 11 bit periods.
- tx_valid held high with bytes 0x01,0x02, STOP_BITS=2: two complete frames; line high for at least 2 bit periods between them; exactly two tx_done pulses; tx_ready high for exactly one cycle between frames.
- Accept coincident with a baud_tick: the start bit begins on the following tick, not the coincident one; no bit period is shortened.
- Assert reset for 1 cycle during data bit 3: tx_out=1 on the next clock; tx_ready=1 after release; no tx_done; the next frame is transmitted correctly.
- Change tx_data every cycle after accepting 0xF0: the transmitted bits match 0xF0.
